// File: rtl/writeback_unit_if.sv
// Result/load/issue handshakes plus the register-file write port and scoreboard of the writeback unit.
// The slave modport is the writeback unit; the master modport is the producer/consumer side.
interface writeback_unit_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            ld_valid;
  logic            ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_offset;
  logic [XLEN-1:0] ld_rdata;

  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;

  logic [NREG-1:0] busy;
  logic            w_enabled;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;
  logic            ld_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_funct3, ld_offset, ld_rdata,
    input  issue_valid, issue_rd,
    output alu_ready, ld_ready, issue_ready,
    output busy, w_enabled, w_addr, w_data, ld_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_funct3, ld_offset, ld_rdata,
    output issue_valid, issue_rd,
    input  alu_ready, ld_ready, issue_ready,
    input  busy, w_enabled, w_addr, w_data, ld_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write master: round-robin between ALU and load results, load alignment/extension,
// registered write port, and a busy scoreboard of in-flight load destinations.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic           clk,
  input  logic           rstn,
  writeback_unit_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  src_e            rr_q, rr_d;
  logic            w_enabled_q, w_enabled_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            ld_err_q, ld_err_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            alu_fire;
  logic            ld_fire;
  logic            issue_fire;
  logic            ld_bad;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_value;

  // rr_q names the source that wins when both are valid; a lone valid source always wins.
  assign bus.alu_ready   = !bus.ld_valid || (rr_q == SRC_ALU);
  assign bus.ld_ready    = !bus.alu_valid || (rr_q == SRC_LD);
  assign bus.issue_ready = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];

  assign alu_fire   = bus.alu_valid && bus.alu_ready;
  assign ld_fire    = bus.ld_valid && bus.ld_ready;
  assign issue_fire = bus.issue_valid && bus.issue_ready;

  assign ld_byte = bus.ld_rdata[{bus.ld_offset, 3'b000} +: 8];
  assign ld_half = bus.ld_rdata[{bus.ld_offset[1], 4'b0000} +: 16];

  always_comb begin
    ld_bad   = 1'b0;
    ld_value = '0;
    case (bus.ld_funct3)
      3'b000: ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_value = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        if (bus.ld_offset[0]) ld_bad = 1'b1;
        else                  ld_value = {{(XLEN-16){ld_half[15]}}, ld_half};
      end
      3'b101: begin
        if (bus.ld_offset[0]) ld_bad = 1'b1;
        else                  ld_value = {{(XLEN-16){1'b0}}, ld_half};
      end
      3'b010: begin
        if (bus.ld_offset != 2'b00) ld_bad = 1'b1;
        else                        ld_value = bus.ld_rdata;
      end
      default: ld_bad = 1'b1;
    endcase
  end

  always_comb begin
    rr_d        = rr_q;
    w_enabled_d = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    ld_err_d    = 1'b0;
    busy_d      = busy_q;

    if (alu_fire) begin
      rr_d = SRC_LD;
      if (bus.alu_rd != '0) begin
        w_enabled_d = 1'b1;
        w_addr_d    = bus.alu_rd;
        w_data_d    = bus.alu_data;
      end
    end else if (ld_fire) begin
      rr_d                = SRC_ALU;
      ld_err_d            = ld_bad;
      busy_d[bus.ld_rd]   = 1'b0;
      if (!ld_bad && (bus.ld_rd != '0)) begin
        w_enabled_d = 1'b1;
        w_addr_d    = bus.ld_rd;
        w_data_d    = ld_value;
      end
    end

    // Applied after the load clear so a same-edge issue to that register stays busy.
    if (issue_fire && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q        <= SRC_ALU;
      w_enabled_q <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      ld_err_q    <= 1'b0;
      busy_q      <= '0;
    end else begin
      rr_q        <= rr_d;
      w_enabled_q <= w_enabled_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      ld_err_q    <= ld_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.w_enabled = w_enabled_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.w_data    = w_data_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of arbitration, load extraction and the busy scoreboard.
module tb_writeback_unit;
  logic clk  = 1'b0;
  logic rstn = 1'b0;

  writeback_unit_if bus ();

  writeback_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;
  bit  mdl_busy[32];
  bit  mdl_pref_alu = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Load extraction from the architectural rules, using plain integer shifts and modular arithmetic.
  function automatic void model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata,
                                     output bit err, output logic [31:0] val);
    int unsigned word, b, h;
    word = rdata;
    b    = (word >> (8 * off)) % 256;
    h    = (word >> (8 * off)) % 65536;
    err  = 1'b0;
    val  = '0;
    case (f3)
      3'd0: val = (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'd4: val = 32'(b);
      3'd1: if (off % 2 != 0) err = 1'b1; else val = (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'd5: if (off % 2 != 0) err = 1'b1; else val = 32'(h);
      3'd2: if (off != 0) err = 1'b1; else val = rdata;
      default: err = 1'b1;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
    mdl_pref_alu = 1'b1;
  endfunction

  // Drives one cycle of inputs at the falling edge, checks handshake outputs against the model,
  // pushes expected writebacks, and returns on the following rising edge.
  task automatic applyStimulus(
    input bit av, input logic [4:0] ar, input logic [31:0] ad,
    input bit lv, input logic [4:0] lr, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] lrd,
    input bit iv, input logic [4:0] ir,
    output bit alu_taken, output bit ld_taken);
    logic [31:0] busy_exp;
    bit          grant_alu, grant_ld, iss_ok, err;
    logic [31:0] val;
    wr_t         e;

    @(negedge clk);
    for (int i = 0; i < 32; i++) busy_exp[i] = mdl_busy[i];
    checkOutput("busy", bus.busy, busy_exp);

    bus.alu_valid   = av;  bus.alu_rd = ar;  bus.alu_data = ad;
    bus.ld_valid    = lv;  bus.ld_rd  = lr;  bus.ld_funct3 = f3;
    bus.ld_offset   = off; bus.ld_rdata = lrd;
    bus.issue_valid = iv;  bus.issue_rd = ir;
    #1;

    grant_alu = av && (!lv || mdl_pref_alu);
    grant_ld  = lv && !grant_alu;
    iss_ok    = (ir == 5'd0) || !mdl_busy[ir];
    if (av) checkOutput("alu_ready", 32'(bus.alu_ready), 32'(grant_alu));
    if (lv) checkOutput("ld_ready", 32'(bus.ld_ready), 32'(grant_ld));
    if (iv) checkOutput("issue_ready", 32'(bus.issue_ready), 32'(iss_ok));

    if (grant_alu) begin
      mdl_pref_alu = 1'b0;
      if (ar != 5'd0) begin
        e = '{err: 1'b0, addr: ar, data: ad};
        exp_q.push_back(e);
      end
    end
    if (grant_ld) begin
      mdl_pref_alu = 1'b1;
      model_load(f3, off, lrd, err, val);
      if (err) begin
        e = '{err: 1'b1, addr: 5'd0, data: 32'd0};
        exp_q.push_back(e);
      end else if (lr != 5'd0) begin
        e = '{err: 1'b0, addr: lr, data: val};
        exp_q.push_back(e);
      end
      mdl_busy[lr] = 1'b0;
    end
    if (iv && iss_ok && (ir != 5'd0)) mdl_busy[ir] = 1'b1;

    alu_taken = grant_alu;
    ld_taken  = grant_ld;
    @(posedge clk);
  endtask

  // Monitor: every presented write or error pulse is matched against the oldest expected entry.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (rstn && (bus.w_enabled || bus.ld_err)) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: w_enabled=%0b ld_err=%0b w_addr=%0d, expected no output",
                 bus.w_enabled, bus.ld_err, bus.w_addr);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ld_err", 32'(bus.ld_err), 32'(e.err));
        checkOutput("w_enabled", 32'(bus.w_enabled), 32'(!e.err));
        if (!e.err) begin
          checkOutput("w_addr", 32'(bus.w_addr), 32'(e.addr));
          checkOutput("w_data", bus.w_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          at, lt;
    bit          ap, lp;
    logic [4:0]  ar, lr, ir;
    logic [31:0] ad, lrd;
    logic [2:0]  f3;
    logic [1:0]  off;
    bit          iv;
    logic [2:0]  legal_f3 [5];

    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    model_reset();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_funct3 = '0; bus.ld_offset = '0; bus.ld_rdata = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;

    #12;
    checkOutput("reset_w_enabled", 32'(bus.w_enabled), 32'd0);
    checkOutput("reset_w_addr", 32'(bus.w_addr), 32'd0);
    checkOutput("reset_w_data", bus.w_data, 32'd0);
    checkOutput("reset_ld_err", 32'(bus.ld_err), 32'd0);
    checkOutput("reset_busy", bus.busy, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] ALU only write");
    applyStimulus(1, 5'd5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, at, lt);

    $display("[TB] load extension cases");
    applyStimulus(0, 0, 0, 1, 5'd10, 3'b000, 2'd3, 32'h80FF_7F01, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd11, 3'b100, 2'd3, 32'h80FF_7F01, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd12, 3'b001, 2'd2, 32'h80FF_7F01, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd13, 3'b101, 2'd0, 32'h80FF_7F01, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd14, 3'b010, 2'd0, 32'h80FF_7F01, 0, 0, at, lt);

    $display("[TB] both sources valid, alternating grants");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'd1, 32'h1111_1111, 1, 5'd2, 3'b010, 2'd0, 32'h2222_2222, 0, 0, at, lt);

    $display("[TB] scoreboard set and clear");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd7, 3'b010, 2'd0, 32'hCAFE_0007, 1, 5'd7, at, lt);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd0, at, lt);

    $display("[TB] x0 write and misaligned load");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, at, lt);
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 1, 5'd3, 3'b010, 2'd1, 32'h1234_5678, 0, 0, at, lt);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, at, lt);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(1, 5'd4, 32'hABCD_0004, 0, 0, 0, 0, 0, 1, 5'd9, at, lt);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_w_enabled", 32'(bus.w_enabled), 32'd0);
    checkOutput("async_reset_busy", bus.busy, 32'd0);
    model_reset();
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0; bus.issue_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] randomized traffic");
    ap = 1'b0; lp = 1'b0;
    ar = '0; ad = '0; lr = '0; f3 = '0; off = '0; lrd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!ap && ($urandom_range(0, 9) < 6)) begin
        ap = 1'b1;
        ar = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!lp && ($urandom_range(0, 9) < 6)) begin
        lp  = 1'b1;
        lr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        f3  = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        off = 2'($urandom_range(0, 3));
        lrd = $urandom;
      end
      iv = ($urandom_range(0, 9) < 4);
      ir = 5'($urandom_range(0, 7));
      applyStimulus(ap, ar, ad, lp, lr, f3, off, lrd, iv, ir, at, lt);
      if (at) ap = 1'b0;
      if (lt) lp = 1'b0;
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, at, lt);
    #2;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
